fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one-entry skid buffer and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // ST_REQ: fetching from memory; ST_BUF: a word is parked in the skid buffer
    typedef enum logic {
        ST_REQ = 1'b0,
        ST_BUF = 1'b1
    } fetchState_t;

    fetchState_t state;
    fetchState_t stateNext;

    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] pcPlus4;
    logic [31:0] bufInstr;
    logic [31:0] bufInstrNext;
    logic [31:0] bufPc;
    logic [31:0] bufPcNext;

    logic        validNext;
    logic [31:0] instrNext;
    logic [31:0] idPcNext;
    logic [31:0] idPc4Next;

    // Wraps modulo 2^32 naturally through the 32-bit width
    assign pcPlus4 = pc + 32'd4;

    // Memory request is only issued while the skid buffer is empty
    always_comb begin
        imem_req  = (state == ST_REQ);
        imem_addr = pc[31:2];
    end

    // Next-state and next-value logic; redirect outranks everything except reset
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        bufInstrNext = bufInstr;
        bufPcNext    = bufPc;
        validNext    = if_id_valid;
        instrNext    = if_id_instr;
        idPcNext     = if_id_pc;
        idPc4Next    = if_id_pc4;

        if (redirect) begin
            // Any ack arriving this cycle belongs to the stale path and is dropped
            pcNext       = {redirect_pc[31:2], 2'b00};
            stateNext    = ST_REQ;
            bufInstrNext = NOP_INSTR;
            bufPcNext    = 32'h00000000;
            validNext    = 1'b0;
            instrNext    = NOP_INSTR;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ack) begin
                        pcNext = pcPlus4;
                        if (stall) begin
                            // Decode is busy: park the word and stop requesting
                            bufInstrNext = imem_data;
                            bufPcNext    = pc;
                            stateNext    = ST_BUF;
                        end else begin
                            validNext = 1'b1;
                            instrNext = imem_data;
                            idPcNext  = pc;
                            idPc4Next = pcPlus4;
                        end
                    end else if (!stall) begin
                        // No word this cycle: hand decode a bubble
                        validNext = 1'b0;
                        instrNext = NOP_INSTR;
                    end
                end
                ST_BUF: begin
                    if (!stall) begin
                        validNext = 1'b1;
                        instrNext = bufInstr;
                        idPcNext  = bufPc;
                        idPc4Next = bufPc + 32'd4;
                        stateNext = ST_REQ;
                    end
                end
                default: begin
                    stateNext = ST_REQ;
                end
            endcase
        end
    end

    // State, PC, skid buffer and IF/ID register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            bufInstr    <= NOP_INSTR;
            bufPc       <= 32'h00000000;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h00000000;
            if_id_pc4   <= 32'h00000000;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            bufInstr    <= bufInstrNext;
            bufPc       <= bufPcNext;
            if_id_valid <= validNext;
            if_id_instr <= instrNext;
            if_id_pc    <= idPcNext;
            if_id_pc4   <= idPc4Next;
        end
    end

endmodule
